bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) for the reaction tester's display path.
- Sits directly downstream of the 18-bit millisecond counter: it captures `Bin` on a `Start` pulse and presents six BCD digits for the seven-segment decoders.
- Handshake is `Start` / `Busy` / `Done`.
- The result holds on `BCD` until the next conversion completes.

---
 rtl/bin2bcd_seq_if.sv | 22 ++
 rtl/bin2bcd_seq.sv | 138 +++++++++++++
 tb/tb_bin2bcd_seq.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_if.sv
// Start/Busy/Done handshake bundle between a binary source and the bin2bcd_seq converter.
interface bin2bcd_seq_if #(
    parameter int unsigned WIDTH  = 18,
    parameter int unsigned DIGITS = 6
);
    logic                  Start;
    logic [WIDTH-1:0]      Bin;
    logic [4*DIGITS-1:0]   BCD;
    logic                  Busy;
    logic                  Done;
    logic [DIGITS-1:0]     Blank;

    modport master (
        output Start, Bin,
        input  BCD, Busy, Done, Blank
    );

    modport slave (
        input  Start, Bin,
        output BCD, Busy, Done, Blank
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Optional leading-zero mask on Blank is built only when BIN2BCD_BLANK_EN is defined.
module bin2bcd_seq #(
    parameter int unsigned WIDTH  = 18,
    parameter int unsigned DIGITS = 6
) (
    input  logic          Clock,
    input  logic          Resetn,
    bin2bcd_seq_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned SW = 4 * DIGITS;
    localparam int unsigned TW = SW + WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [SW-1:0]   scr_q, scr_d;
    logic [SW-1:0]   bcd_q, bcd_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [SW-1:0]   adj_c;
    logic [TW-1:0]   cat_c;
    logic [SW-1:0]   scr_shf_c;
    logic [WIDTH-1:0] bin_shf_c;

    // Per-digit add-3 correction, applied before the shift; no carry between digits.
    always_comb begin
        adj_c = scr_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) begin
                adj_c[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign cat_c     = {adj_c, bin_q} << 1;
    assign scr_shf_c = cat_c[TW-1:WIDTH];
    assign bin_shf_c = cat_c[WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        bcd_d   = bcd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    bin_d   = bus.Bin;
                    scr_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                scr_d = scr_shf_c;
                bin_d = bin_shf_c;
                cnt_d = cnt_q + CW'(1);
                // Final shift: result is published on the same edge.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    bcd_d   = scr_shf_c;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            scr_q   <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.BCD  = bcd_q;
    assign bus.Busy = busy_q;
    assign bus.Done = done_q;

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q;
    logic [DIGITS-1:0] lz_c;

    // Digit i is blanked when it and every higher digit are zero; units never blanked.
    always_comb begin : lz_mask
        logic hz;
        hz   = 1'b1;
        lz_c = '0;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            hz      = hz & (scr_shf_c[4*i +: 4] == 4'd0);
            lz_c[i] = hz;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            blank_q <= '0;
        end else if (done_d) begin
            blank_q <= lz_c;
        end
    end

    assign bus.Blank = blank_q;
`else
    assign bus.Blank = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: random and directed conversions against a decimal-arithmetic model.
module tb_bin2bcd_seq;
    localparam int unsigned W = 18;
    localparam int unsigned D = 6;
    localparam int unsigned MAXV = (1 << W) - 1;

    typedef struct {
        int unsigned val;
        int unsigned bcd;
        int unsigned blank;
        int unsigned acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc = 0;
    int unsigned total = 0;
    int unsigned bad = 0;
    exp_t        sb[$];

    bin2bcd_seq_if #(.WIDTH(W), .DIGITS(D)) bus ();

    bin2bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
        .Clock  (clk),
        .Resetn (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: decimal digits by repeated division, blank mask by magnitude.
    function automatic exp_t model(input int unsigned v, input int unsigned acc);
        exp_t        e;
        int unsigned t;
        int unsigned p;
        e.val   = v;
        e.acc   = acc;
        e.bcd   = 0;
        e.blank = 0;
        t = v;
        for (int i = 0; i < int'(D); i++) begin
            e.bcd = e.bcd + ((t % 10) << (4 * i));
            t = t / 10;
        end
`ifdef BIN2BCD_BLANK_EN
        p = 1;
        for (int i = 1; i < int'(D); i++) begin
            p = p * 10;
            if (v < p) e.blank = e.blank | (1 << i);
        end
`else
        p = 0;
`endif
        return e;
    endfunction

    task automatic drain(input int unsigned limit);
        int unsigned k;
        k = 0;
        while (sb.size() != 0 && k < limit) begin
            @(posedge clk);
            k++;
        end
        check("drain", sb.size(), 0);
        sb.delete();
    endtask

    task automatic convert(input int unsigned v);
        @(negedge clk);
        bus.Start = 1'b1;
        bus.Bin   = W'(v);
        @(posedge clk);
        #1;
        sb.push_back(model(v, cyc));
        @(negedge clk);
        bus.Start = 1'b0;
        bus.Bin   = W'($urandom);
        drain(W + 6);
    endtask

    initial begin
        int unsigned a0;
        bus.Start = 1'b0;
        bus.Bin   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Monitor: pops the scoreboard whenever Done is presented.
        fork
            begin
                int unsigned busy_run;
                bit          prev_done;
                busy_run  = 0;
                prev_done = 1'b0;
                forever begin
                    @(negedge clk);
                    if (!rst_n) begin
                        busy_run  = 0;
                        prev_done = 1'b0;
                    end else begin
                        if (bus.Busy) busy_run++;
                        if (prev_done) check("done_width", 32'(bus.Done), 0);
                        if (bus.Done) begin
                            if (sb.size() == 0) begin
                                check("unexpected_done", 1, 0);
                            end else begin
                                exp_t        e;
                                int unsigned dec;
                                int unsigned dig_ok;
                                logic [3:0]  d;
                                e      = sb.pop_front();
                                dec    = 0;
                                dig_ok = 1;
                                for (int i = int'(D) - 1; i >= 0; i--) begin
                                    d = bus.BCD[4*i +: 4];
                                    if (d > 4'd9) dig_ok = 0;
                                    dec = dec * 10 + 32'(d);
                                end
                                check("bcd", 32'(bus.BCD), e.bcd);
                                check("digits_le9", dig_ok, 1);
                                check("decoded", dec, e.val);
                                check("blank", 32'(bus.Blank), e.blank);
                                check("latency", cyc - e.acc, W);
                                check("busy_cycles", busy_run, W);
                                check("busy_at_done", 32'(bus.Busy), 0);
                            end
                            busy_run = 0;
                        end
                        prev_done = bus.Done;
                    end
                end
            end
        join_none

        @(negedge clk);
        check("rst_bcd", 32'(bus.BCD), 0);
        check("rst_busy", 32'(bus.Busy), 0);
        check("rst_done", 32'(bus.Done), 0);
        check("rst_blank", 32'(bus.Blank), 0);

        convert(0);
        convert(MAXV);

        // Second Start during SHIFT must be ignored.
        @(negedge clk);
        bus.Start = 1'b1;
        bus.Bin   = W'(999);
        @(posedge clk);
        #1;
        sb.push_back(model(999, cyc));
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (4) @(negedge clk);
        bus.Start = 1'b1;
        bus.Bin   = W'(1);
        @(negedge clk);
        bus.Start = 1'b0;
        drain(W + 6);
        repeat (3) @(posedge clk);
        #1;
        check("ignored_start_busy", 32'(bus.Busy), 0);
        repeat (W + 4) @(posedge clk);

        // Reset mid-conversion: outputs clear at once, no Done follows.
        @(negedge clk);
        bus.Start = 1'b1;
        bus.Bin   = W'(1234);
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (8) @(negedge clk);
        check("busy_before_rst", 32'(bus.Busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_bcd", 32'(bus.BCD), 0);
        check("midrst_busy", 32'(bus.Busy), 0);
        check("midrst_done", 32'(bus.Done), 0);
        check("midrst_blank", 32'(bus.Blank), 0);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (W + 6) @(posedge clk);
        #1;
        check("post_rst_bcd", 32'(bus.BCD), 0);

        // Start held high: one conversion every W+2 clocks.
        @(negedge clk);
        bus.Start = 1'b1;
        bus.Bin   = W'(4321);
        @(posedge clk);
        #1;
        a0 = cyc;
        for (int k = 0; k < 3; k++) sb.push_back(model(4321, a0 + k * (W + 2)));
        repeat (2 * (W + 2)) @(posedge clk);
        @(negedge clk);
        bus.Start = 1'b0;
        drain(W + 6);

        for (int unsigned v = 0; v < 200; v++) convert(v);
        for (int unsigned v = 9990; v < 10000; v++) convert(v);
        convert(10000);
        convert(99999);
        convert(100000);
        convert(MAXV - 1);
        for (int k = 0; k < 400; k++) convert($urandom_range(MAXV, 0));

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
